regbank_ctrl: RTL and testbench

REGBANK_CTRL -- requirements
Module: regbank_ctrl

---
 rtl/regbank_ctrl.sv | 104 ++++++++++
 tb/tb_regbank_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regbank_ctrl.sv
// Register-bank issue/writeback controller: scoreboarded issue gating plus a
// round-robin arbiter feeding a single registered write port.
module regbank_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic [3:0]  iss_rs1,
  input  logic [3:0]  iss_rs2,
  input  logic [3:0]  iss_rd,
  input  logic        iss_use_rs1,
  input  logic        iss_use_rs2,
  input  logic        iss_wr,
  input  logic        alu_wb_valid,
  input  logic        mem_wb_valid,
  input  logic [3:0]  alu_wb_rd,
  input  logic [3:0]  mem_wb_rd,
  input  logic [31:0] alu_wb_data,
  input  logic [31:0] mem_wb_data,
  output logic        alu_wb_ready,
  output logic        mem_wb_ready,
  output logic [3:0]  rad1,
  output logic [3:0]  rad2,
  output logic [3:0]  wad,
  output logic        r1,
  output logic        r2,
  output logic        wen,
  output logic [31:0] wdata,
  output logic [15:0] pending,
  output logic        busy,
  output logic        wb_err
);

  typedef enum logic {PRI_ALU, PRI_MEM} pri_t;

  pri_t        pri_q, pri_d;
  logic [15:0] pending_d;
  logic        wen_d, err_d;
  logic [3:0]  wad_d;
  logic [31:0] wdata_d;
  logic        hazard, fire, alu_grant, mem_grant;

  always_comb begin
    hazard = (iss_use_rs1 && pending[iss_rs1]) ||
             (iss_use_rs2 && pending[iss_rs2]) ||
             (iss_wr      && pending[iss_rd]);
    iss_ready = !rst && !hazard;
    fire      = iss_valid && iss_ready;
    rad1      = iss_rs1;
    rad2      = iss_rs2;
    r1        = fire && iss_use_rs1;
    r2        = fire && iss_use_rs2;

    alu_wb_ready = !rst && (!mem_wb_valid || pri_q == PRI_ALU);
    mem_wb_ready = !rst && (!alu_wb_valid || pri_q == PRI_MEM);
    alu_grant    = alu_wb_valid && alu_wb_ready;
    mem_grant    = mem_wb_valid && mem_wb_ready;

    // Pointer only moves on a conflict: the loser gets priority next time.
    pri_d = pri_q;
    if (alu_wb_valid && mem_wb_valid)
      pri_d = alu_grant ? PRI_MEM : PRI_ALU;

    pending_d = pending;
    if (wen)
      pending_d[wad] = 1'b0;
    if (fire && iss_wr)
      pending_d[iss_rd] = 1'b1;

    err_d = wb_err || (wen && !pending[wad]);

    wen_d   = alu_grant || mem_grant;
    wad_d   = wad;
    wdata_d = wdata;
    if (alu_grant) begin
      wad_d   = alu_wb_rd;
      wdata_d = alu_wb_data;
    end else if (mem_grant) begin
      wad_d   = mem_wb_rd;
      wdata_d = mem_wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q   <= PRI_ALU;
      pending <= '0;
      wb_err  <= 1'b0;
      wen     <= 1'b0;
      wad     <= '0;
      wdata   <= '0;
    end else begin
      pri_q   <= pri_d;
      pending <= pending_d;
      wb_err  <= err_d;
      wen     <= wen_d;
      wad     <= wad_d;
      wdata   <= wdata_d;
    end
  end

  assign busy = |pending;

endmodule

// File: tb/tb_regbank_ctrl.sv
// Self-checking bench for regbank_ctrl: directed scenarios then random traffic,
// all compared cycle by cycle against a behavioural scoreboard model.
module tb_regbank_ctrl;

  logic        clk = 1'b0;
  logic        rst, iss_valid, iss_ready;
  logic [3:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_use_rs1, iss_use_rs2, iss_wr;
  logic        alu_wb_valid, mem_wb_valid, alu_wb_ready, mem_wb_ready;
  logic [3:0]  alu_wb_rd, mem_wb_rd, rad1, rad2, wad;
  logic [31:0] alu_wb_data, mem_wb_data, wdata;
  logic        r1, r2, wen, busy, wb_err;
  logic [15:0] pending;

  regbank_ctrl dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_use_rs1(iss_use_rs1), .iss_use_rs2(iss_use_rs2), .iss_wr(iss_wr),
    .alu_wb_valid(alu_wb_valid), .mem_wb_valid(mem_wb_valid),
    .alu_wb_rd(alu_wb_rd), .mem_wb_rd(mem_wb_rd),
    .alu_wb_data(alu_wb_data), .mem_wb_data(mem_wb_data),
    .alu_wb_ready(alu_wb_ready), .mem_wb_ready(mem_wb_ready),
    .rad1(rad1), .rad2(rad2), .wad(wad), .r1(r1), .r2(r2), .wen(wen),
    .wdata(wdata), .pending(pending), .busy(busy), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: set of outstanding registers, the one write awaiting the
  // port, the sticky error, and which source won the last contested cycle.
  bit          m_out[16];
  bit          m_err;
  bit          m_wr_now;
  int unsigned m_wr_reg;
  logic [31:0] m_wr_val;
  bit          m_mem_won_last;

  function automatic logic [15:0] m_vec();
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = m_out[i];
    return v;
  endfunction

  task automatic model_reset();
    foreach (m_out[i]) m_out[i] = 1'b0;
    m_err = 0; m_wr_now = 0; m_wr_reg = 0; m_wr_val = '0;
    m_mem_won_last = 1;
  endtask

  // One clock cycle with whatever inputs are currently driven.
  task automatic tick();
    bit stall, go, g_alu, g_mem;
    #1;
    stall = (iss_use_rs1 && m_out[iss_rs1]) || (iss_use_rs2 && m_out[iss_rs2]) ||
            (iss_wr && m_out[iss_rd]);
    go    = iss_valid && !rst && !stall;
    g_alu = 0; g_mem = 0;
    if (!rst) begin
      if (alu_wb_valid && mem_wb_valid) begin
        g_alu = m_mem_won_last;
        g_mem = !m_mem_won_last;
      end else begin
        g_alu = alu_wb_valid;
        g_mem = mem_wb_valid;
      end
    end
    check("iss_ready", iss_ready, !rst && !stall);
    check("r1", r1, go && iss_use_rs1);
    check("r2", r2, go && iss_use_rs2);
    check("rad1", rad1, iss_rs1);
    check("rad2", rad2, iss_rs2);
    check("alu_grant", alu_wb_valid && alu_wb_ready, g_alu);
    check("mem_grant", mem_wb_valid && mem_wb_ready, g_mem);

    if (rst) begin
      model_reset();
    end else begin
      if (alu_wb_valid && mem_wb_valid) m_mem_won_last = g_mem;
      if (m_wr_now) begin
        if (!m_out[m_wr_reg]) m_err = 1;
        m_out[m_wr_reg] = 0;
      end
      if (go && iss_wr) m_out[iss_rd] = 1;
      m_wr_now = g_alu || g_mem;
      if (g_alu) begin m_wr_reg = alu_wb_rd; m_wr_val = alu_wb_data; end
      else if (g_mem) begin m_wr_reg = mem_wb_rd; m_wr_val = mem_wb_data; end
    end

    @(posedge clk); #1;
    check("wen", wen, m_wr_now);
    check("wad", wad, m_wr_reg);
    check("wdata", wdata, m_wr_val);
    check("pending", pending, m_vec());
    check("busy", busy, m_vec() != 0);
    check("wb_err", wb_err, m_err);
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_use_rs1 = 0; iss_use_rs2 = 0; iss_wr = 0;
    iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    alu_wb_valid = 0; mem_wb_valid = 0;
    alu_wb_rd = 0; mem_wb_rd = 0; alu_wb_data = 0; mem_wb_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; tick(); tick();
    rst = 0;
  endtask

  initial begin
    logic [3:0] exp_wad[3];
    exp_wad[0] = 4'd3; exp_wad[1] = 4'd7; exp_wad[2] = 4'd3;
    model_reset();
    do_reset();
    check("reset_pending", pending, 16'h0);
    check("reset_wen", wen, 1'b0);

    // RAW stall on r5 released two cycles after its grant
    iss_valid = 1; iss_wr = 1; iss_rd = 5; tick();
    iss_wr = 0; iss_use_rs1 = 1; iss_rs1 = 5; tick();
    check("raw_stall", iss_ready, 1'b0);
    alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 32'h55; tick();
    check("raw_wen", wen, 1'b1);
    check("raw_wad", wad, 4'd5);
    check("raw_still_stalled", iss_ready, 1'b0);
    alu_wb_valid = 0; tick();
    check("raw_release", iss_ready, 1'b1);

    // Contested writeback: ALU, MEM, ALU
    do_reset();
    alu_wb_valid = 1; alu_wb_rd = 3; alu_wb_data = 32'hA3;
    mem_wb_valid = 1; mem_wb_rd = 7; mem_wb_data = 32'hB7;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rr_wad", wad, exp_wad[i]);
    end
    idle_inputs(); tick();

    // WAW stall on r9
    do_reset();
    iss_valid = 1; iss_wr = 1; iss_rd = 9; tick();
    check("waw_stall", iss_ready, 1'b0);
    mem_wb_valid = 1; mem_wb_rd = 9; mem_wb_data = 32'h9; tick();
    mem_wb_valid = 0; tick();
    check("waw_release", iss_ready, 1'b1);
    idle_inputs(); tick();

    // Unexpected writeback sets sticky error
    do_reset();
    mem_wb_valid = 1; mem_wb_rd = 12; mem_wb_data = 32'hDEADBEEF; tick();
    mem_wb_valid = 0;
    check("err_wad", wad, 4'd12);
    check("err_wdata", wdata, 32'hDEADBEEF);
    tick(); tick(); tick();
    check("err_sticky", wb_err, 1'b1);

    // Simultaneous set of r4 and clear of r2
    do_reset();
    iss_valid = 1; iss_wr = 1; iss_rd = 2; tick();
    iss_valid = 0; alu_wb_valid = 1; alu_wb_rd = 2; tick();
    alu_wb_valid = 0; iss_valid = 1; iss_rd = 4; tick();
    check("setclr_p4", pending[4], 1'b1);
    check("setclr_p2", pending[2], 1'b0);
    idle_inputs();

    // Reset discards a granted write
    alu_wb_valid = 1; alu_wb_rd = 6; tick();
    alu_wb_valid = 0; rst = 1; tick();
    check("rst_wen", wen, 1'b0);
    check("rst_pending", pending, 16'h0);
    check("rst_busy", busy, 1'b0);
    rst = 0;

    // Random traffic with a narrow register range to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      bit narrow;
      narrow = $urandom_range(0, 1) != 0;
      rst          = ($urandom_range(0, 149) == 0);
      iss_valid    = $urandom_range(0, 3) != 0;
      iss_rs1      = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom);
      iss_rs2      = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom);
      iss_rd       = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom);
      iss_use_rs1  = 1'($urandom);
      iss_use_rs2  = 1'($urandom);
      iss_wr       = 1'($urandom);
      alu_wb_valid = $urandom_range(0, 2) == 0;
      mem_wb_valid = $urandom_range(0, 2) == 0;
      alu_wb_rd    = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom);
      mem_wb_rd    = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom);
      alu_wb_data  = $urandom;
      mem_wb_data  = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
